// File: rtl/prog_sequencer.sv
// Program-flow sequencer: selects a program slot on Start, then steps or branches the
// fetch PC each cycle until a halt word or the cycle budget ends the run.
module prog_sequencer #(
    parameter int PC_W        = 8,
    parameter int INSTR_W     = 9,
    parameter int HALT_CODE   = 0,
    parameter int NUM_PROGS   = 3,
    parameter int SEL_W       = 2,
    parameter int PROG_STRIDE = 64,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 65535
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [SEL_W-1:0]   i_prog_sel,
    input  logic [INSTR_W-1:0] i_instruction,
    input  logic               i_branch_rel,
    input  logic               i_zero,
    input  logic [PC_W-1:0]    i_target,
    input  logic               i_stall,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_run,
    output logic               o_ack,
    output logic [CNT_W-1:0]   o_cycle_count,
    output logic               o_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]    PC_ONE      = PC_W'(1);
    localparam logic [PC_W-1:0]    STRIDE      = PC_W'(PROG_STRIDE);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   LAST_CYCLE  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]   BUDGET      = CNT_W'(MAX_CYCLES);
    localparam logic [INSTR_W-1:0] HALT_WORD   = INSTR_W'(HALT_CODE);
    localparam logic [SEL_W:0]     NUM_PROGS_W = (SEL_W + 1)'(NUM_PROGS);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_run;
    logic              r_ack;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_fault;

    logic              w_sel_ok;
    logic [PC_W-1:0]   w_base;

    // Slot base wraps modulo 2^PC_W, which the PC_W-wide product gives for free.
    assign w_sel_ok = ({1'b0, i_prog_sel} < NUM_PROGS_W);
    assign w_base   = PC_W'(i_prog_sel) * STRIDE;

    // Run-control FSM with PC, cycle counter and sticky fault kept alongside the state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_run   <= 1'b0;
            r_ack   <= 1'b0;
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start && w_sel_ok) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                        r_ack   <= 1'b0;
                        r_pc    <= w_base;
                        r_cnt   <= '0;
                        r_fault <= 1'b0;
                    end else if (i_start) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_fault <= r_fault;
                    end
                end
                S_RUN: begin
                    // Timeout outranks stall and halt so a stalled or looping program still ends.
                    if (r_cnt == LAST_CYCLE) begin
                        r_state <= S_DONE;
                        r_run   <= 1'b0;
                        r_ack   <= 1'b1;
                        r_fault <= 1'b1;
                        r_cnt   <= BUDGET;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (i_stall) begin
                            r_pc <= r_pc;
                        end else if (i_instruction == HALT_WORD) begin
                            r_state <= S_DONE;
                            r_run   <= 1'b0;
                            r_ack   <= 1'b1;
                        end else if (i_branch_rel && i_zero) begin
                            r_pc <= r_pc + i_target;
                        end else begin
                            r_pc <= r_pc + PC_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pc    <= '0;
                    r_run   <= 1'b0;
                    r_ack   <= 1'b0;
                    r_cnt   <= '0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_run         = r_run;
    assign o_ack         = r_ack;
    assign o_cycle_count = r_cnt;
    assign o_fault       = r_fault;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: stimulus queues hand-computed expectations tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_prog_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  prog_sel;
    logic [8:0]  instruction;
    logic        branch_rel;
    logic        zero;
    logic [7:0]  target;
    logic        stall;
    logic [7:0]  pc;
    logic        run;
    logic        ack;
    logic [15:0] cycle_count;
    logic        fault;

    logic [8:0]  rom [256];

    typedef struct {
        int          cyc;
        logic [7:0]  pc;
        logic        run;
        logic        ack;
        logic        fault;
        logic [15:0] cnt;
    } exp_t;

    exp_t  sb [$];
    string sb_name [$];
    int    cyc;
    int    checks;
    int    errors;

    prog_sequencer #(
        .MAX_CYCLES(20)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_prog_sel    (prog_sel),
        .i_instruction (instruction),
        .i_branch_rel  (branch_rel),
        .i_zero        (zero),
        .i_target      (target),
        .i_stall       (stall),
        .o_pc          (pc),
        .o_run         (run),
        .o_ack         (ack),
        .o_cycle_count (cycle_count),
        .o_fault       (fault)
    );

    assign instruction = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input string field, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s.%s actual=%0h expected=%0h (cycle %0d)", nm, field, act, exp, cyc);
        end
    endtask

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t  e;
            string nm;
            e  = sb.pop_front();
            nm = sb_name.pop_front();
            check(nm, "due", 16'(cyc), 16'(e.cyc));
            check(nm, "pc",    {8'h00, pc},     {8'h00, e.pc});
            check(nm, "run",   {15'h0, run},    {15'h0, e.run});
            check(nm, "ack",   {15'h0, ack},    {15'h0, e.ack});
            check(nm, "fault", {15'h0, fault},  {15'h0, e.fault});
            check(nm, "cnt",   cycle_count,     e.cnt);
        end
    end

    task automatic tick(input string nm, input logic [7:0] e_pc, input logic e_run,
                        input logic e_ack, input logic e_fault, input logic [15:0] e_cnt);
        exp_t e;
        e.cyc   = cyc + 1;
        e.pc    = e_pc;
        e.run   = e_run;
        e.ack   = e_ack;
        e.fault = e_fault;
        e.cnt   = e_cnt;
        sb.push_back(e);
        sb_name.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic quiet();
        reset      = 1'b0;
        start      = 1'b0;
        prog_sel   = 2'd0;
        branch_rel = 1'b0;
        zero       = 1'b0;
        target     = 8'h00;
        stall      = 1'b0;
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) rom[i] = 9'h001;
        rom[64] = 9'h011;
        rom[65] = 9'h022;
        rom[66] = 9'h033;
        rom[67] = 9'h000;
        quiet();

        reset = 1'b1;
        tick("reset0", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        tick("reset1", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick("idle_hold", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Slot 1: three words then halt at 67.
        start = 1'b1; prog_sel = 2'd1;
        tick("slot1_start", 8'd64, 1'b1, 1'b0, 1'b0, 16'd0);
        quiet();
        tick("slot1_s1", 8'd65, 1'b1, 1'b0, 1'b0, 16'd1);
        tick("slot1_s2", 8'd66, 1'b1, 1'b0, 1'b0, 16'd2);
        tick("slot1_s3", 8'd67, 1'b1, 1'b0, 1'b0, 16'd3);
        tick("slot1_halt", 8'd67, 1'b0, 1'b1, 1'b0, 16'd4);
        tick("slot1_done_hold", 8'd67, 1'b0, 1'b1, 1'b0, 16'd4);

        // Branches, wrap and stall-on-halt from slot 0.
        rom[1] = 9'h000;
        start = 1'b1; prog_sel = 2'd0;
        tick("slot0_start", 8'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        quiet();
        branch_rel = 1'b1; zero = 1'b1; target = 8'd10;
        tick("br_to10", 8'd10, 1'b1, 1'b0, 1'b0, 16'd1);
        target = 8'hFB;
        tick("br_minus5", 8'd5, 1'b1, 1'b0, 1'b0, 16'd2);
        target = 8'd5;
        tick("br_plus5", 8'd10, 1'b1, 1'b0, 1'b0, 16'd3);
        zero = 1'b0; target = 8'hFB;
        tick("br_not_taken", 8'd11, 1'b1, 1'b0, 1'b0, 16'd4);
        zero = 1'b1; target = 8'hF4;
        tick("br_to255", 8'd255, 1'b1, 1'b0, 1'b0, 16'd5);
        quiet();
        start = 1'b1; prog_sel = 2'd3;
        tick("wrap_ignore_start", 8'd0, 1'b1, 1'b0, 1'b0, 16'd6);
        quiet();
        tick("seq_to_halt", 8'd1, 1'b1, 1'b0, 1'b0, 16'd7);
        stall = 1'b1;
        tick("stall1", 8'd1, 1'b1, 1'b0, 1'b0, 16'd8);
        tick("stall2", 8'd1, 1'b1, 1'b0, 1'b0, 16'd9);
        stall = 1'b0;
        tick("stall_release", 8'd1, 1'b0, 1'b1, 1'b0, 16'd10);

        // Illegal slot, then timeout on a tight loop.
        start = 1'b1; prog_sel = 2'd3;
        tick("bad_sel", 8'd1, 1'b0, 1'b1, 1'b1, 16'd10);
        prog_sel = 2'd2;
        tick("slot2_start", 8'd128, 1'b1, 1'b0, 1'b0, 16'd0);
        quiet();
        branch_rel = 1'b1; zero = 1'b1; target = 8'd0;
        for (int i = 1; i < 20; i++) tick("tight_loop", 8'd128, 1'b1, 1'b0, 1'b0, 16'(i));
        tick("timeout", 8'd128, 1'b0, 1'b1, 1'b1, 16'd20);
        tick("timeout_hold", 8'd128, 1'b0, 1'b1, 1'b1, 16'd20);
        quiet();

        // Reset mid-run at CycleCount 7.
        rom[1] = 9'h001;
        start = 1'b1; prog_sel = 2'd0;
        tick("run2_start", 8'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        quiet();
        for (int i = 1; i <= 7; i++) tick("run2_seq", 8'(i), 1'b1, 1'b0, 1'b0, 16'(i));
        reset = 1'b1;
        tick("mid_reset", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        tick("post_reset_idle", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        start = 1'b1; prog_sel = 2'd3;
        tick("idle_bad_sel", 8'd0, 1'b0, 1'b0, 1'b1, 16'd0);
        prog_sel = 2'd1; reset = 1'b1;
        tick("reset_wins", 8'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        reset = 1'b0;
        tick("slot1_again", 8'd64, 1'b1, 1'b0, 1'b0, 16'd0);
        quiet();
        tick("slot1b_s1", 8'd65, 1'b1, 1'b0, 1'b0, 16'd1);
        tick("slot1b_s2", 8'd66, 1'b1, 1'b0, 1'b0, 16'd2);
        tick("slot1b_s3", 8'd67, 1'b1, 1'b0, 1'b0, 16'd3);
        tick("slot1b_halt", 8'd67, 1'b0, 1'b1, 1'b0, 16'd4);
        start = 1'b1; prog_sel = 2'd2;
        tick("restart_from_done", 8'd128, 1'b1, 1'b0, 1'b0, 16'd0);
        quiet();

        @(negedge clk);
        @(negedge clk);
        check("drain", "pending", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
